// File: rtl/uart_rx_ctrl_pkg.sv
// Shared definitions for the UART receive controller: sequencer states,
// oversampling ratio and break-length helper.
package uart_rx_ctrl_pkg;

  localparam int UART_OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_SYNC  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } rx_state_e;

  // A break is the line held low for longer than a whole frame: start + data bits + stop.
  function automatic int brk_ticks(input int dbit, input int sb_tick);
    return UART_OVERSAMPLE * (dbit + 1) + sb_tick;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word-fall-through FIFO. The head word is prefetched into a
// register so the storage array only ever sees a registered read.
module uart_rx_fifo #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd,
  output logic [DW-1:0] rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rd_data_q;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          do_wr, do_rd;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;

  // A write into a full FIFO is only accepted when the head is popped in the same cycle.
  assign do_rd = rd & ~empty;
  assign do_wr = wr & (~full | do_rd);

  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Prefetch the word the head pointer will address next, bypassing a same-cycle write.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end
    if (do_wr && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      rd_data_q <= wr_data;
    end else begin
      rd_data_q <= mem[rd_ptr_d[AW-1:0]];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Controller around a 16x-oversampled UART receive core: baud tick, line
// synchroniser, enable/idle/drain sequencing, byte FIFO and status flags.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DBIT      = 8,
  parameter int SB_TICK   = 16,
  parameter int DVSR_W    = 11,
  parameter int FIFO_AW   = 4,
  parameter int IDLE_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic              rx,
  output logic              core_rst,
  output logic              core_rx,
  output logic              core_s_tick,
  input  logic              core_done,
  input  logic [7:0]        core_dout,
  input  logic              rd,
  output logic [7:0]        rd_data,
  output logic              empty,
  output logic              full,
  output logic [FIFO_AW:0]  level,
  output logic              frame_err,
  output logic              overrun,
  output logic              brk,
  input  logic              clr_err,
  output logic              idle_tout,
  output logic              busy
);

  localparam int BRK_LEN = brk_ticks(DBIT, SB_TICK);
  localparam int BRK_W   = $clog2(BRK_LEN + 1);
  localparam int OS_W    = $clog2(UART_OVERSAMPLE);
  localparam int IW      = (IDLE_BITS > 1) ? $clog2(IDLE_BITS) : 1;

  rx_state_e         state_q, state_d;
  logic              rx_meta_q, rx_s_q, rx_s_prev_q;
  logic [DVSR_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [OS_W-1:0]   sync_cnt_q, sync_cnt_d;
  logic [BRK_W-1:0]  brk_cnt_q, brk_cnt_d;
  logic              busy_q, busy_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic              brk_q, brk_d;
  logic [OS_W-1:0]   idle_tick_q, idle_tick_d;
  logic [IW-1:0]     idle_bit_q, idle_bit_d;
  logic              idle_done_q, idle_done_d;
  logic              idle_tout_q, idle_tout_d;

  logic tick, line_active, rx_fall, sync_done, brk_hit, done_v, idle_run, fifo_wr;

  assign core_rst    = (state_q == ST_OFF) || (state_q == ST_SYNC);
  assign line_active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign core_rx     = line_active ? rx_s_q : 1'b1;

  // >= rather than == so that shrinking dvsr mid-count still produces a tick.
  assign tick        = (state_q != ST_OFF) && (baud_cnt_q >= dvsr);
  assign baud_cnt_d  = ((state_q == ST_OFF) || tick) ? '0 : baud_cnt_q + DVSR_W'(1);
  assign core_s_tick = tick & ~core_rst;

  assign rx_fall   = rx_s_prev_q & ~rx_s_q;
  assign sync_done = (state_q == ST_SYNC) && rx_s_q && tick &&
                     (sync_cnt_q == OS_W'(UART_OVERSAMPLE - 1));
  assign brk_hit   = line_active && !rx_s_q && tick && (brk_cnt_q == BRK_W'(BRK_LEN - 1));
  assign done_v    = core_done & ~core_rst;

  always_comb begin
    sync_cnt_d = '0;
    if ((state_q == ST_SYNC) && rx_s_q) begin
      sync_cnt_d = tick ? sync_cnt_q + OS_W'(1) : sync_cnt_q;
    end
    brk_cnt_d = '0;
    if (line_active && !rx_s_q) begin
      brk_cnt_d = tick ? brk_cnt_q + BRK_W'(1) : brk_cnt_q;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OFF:   if (en) state_d = ST_SYNC;
      ST_SYNC: begin
        if (!en)            state_d = ST_OFF;
        else if (sync_done) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (brk_hit)  state_d = ST_SYNC;
        else if (!en) state_d = busy_q ? ST_DRAIN : ST_OFF;
      end
      ST_DRAIN: begin
        if (done_v || brk_hit) state_d = ST_OFF;
        else if (en)           state_d = ST_RUN;
      end
      default:  state_d = ST_OFF;
    endcase
  end

  always_comb begin
    busy_d = busy_q;
    if (!line_active) begin
      busy_d = 1'b0;
    end else begin
      if (done_v) busy_d = 1'b0;
      if (rx_fall && (state_q == ST_RUN)) busy_d = 1'b1;
    end
  end

  // Sticky flags: a set in the same cycle as clr_err takes priority.
  assign fifo_wr     = done_v & (~full | rd);
  assign frame_err_d = (frame_err_q & ~clr_err) | (done_v & ~rx_s_q);
  assign overrun_d   = (overrun_q & ~clr_err) | (done_v & full & ~rd);
  assign brk_d       = (brk_q & ~clr_err) | brk_hit;

  assign idle_run = tick & rx_s_q & ~busy_q & ~empty & ~idle_done_q;

  always_comb begin
    idle_tick_d = idle_tick_q;
    idle_bit_d  = idle_bit_q;
    idle_done_d = idle_done_q;
    idle_tout_d = 1'b0;
    if (done_v) begin
      idle_tick_d = '0;
      idle_bit_d  = '0;
      idle_done_d = 1'b0;
    end else if (idle_run) begin
      idle_tick_d = idle_tick_q + OS_W'(1);
      if (idle_tick_q == OS_W'(UART_OVERSAMPLE - 1)) begin
        if (idle_bit_q == IW'(IDLE_BITS - 1)) begin
          idle_bit_d  = '0;
          idle_tout_d = 1'b1;
          idle_done_d = 1'b1;
        end else begin
          idle_bit_d = idle_bit_q + IW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_OFF;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_s_prev_q <= 1'b1;
      baud_cnt_q  <= '0;
      sync_cnt_q  <= '0;
      brk_cnt_q   <= '0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      brk_q       <= 1'b0;
      idle_tick_q <= '0;
      idle_bit_q  <= '0;
      idle_done_q <= 1'b0;
      idle_tout_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rx_meta_q   <= rx;
      rx_s_q      <= rx_meta_q;
      rx_s_prev_q <= rx_s_q;
      baud_cnt_q  <= baud_cnt_d;
      sync_cnt_q  <= sync_cnt_d;
      brk_cnt_q   <= brk_cnt_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      brk_q       <= brk_d;
      idle_tick_q <= idle_tick_d;
      idle_bit_q  <= idle_bit_d;
      idle_done_q <= idle_done_d;
      idle_tout_q <= idle_tout_d;
    end
  end

  uart_rx_fifo #(
    .DW (8),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr      (fifo_wr),
    .wr_data (core_dout),
    .rd      (rd),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign brk       = brk_q;
  assign idle_tout = idle_tout_q;

endmodule
